// File: rtl/tl_defs.sv
// Shared light-code and state encodings for the left-turn traffic light controller and its monitor.
package tl_defs;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] LEFT   = 2'b10;
    localparam logic [1:0] RED    = 2'b11;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    typedef enum logic {
        MODE_UNLOCKED = 1'b0,
        MODE_LOCKED   = 1'b1
    } mon_mode_e;

    // {La,Lb} that the controller drives while in state st.
    function automatic logic [3:0] exp_pair(input logic [2:0] st);
        logic [3:0] pair;
        case (st)
            S0:      pair = {GREEN,  RED};
            S1:      pair = {YELLOW, RED};
            S2:      pair = {LEFT,   RED};
            S3:      pair = {YELLOW, RED};
            S4:      pair = {RED,    GREEN};
            S5:      pair = {RED,    YELLOW};
            S6:      pair = {RED,    LEFT};
            S7:      pair = {RED,    YELLOW};
            default: pair = {RED,    RED};
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/tl_pair_decode.sv
// Combinational classifier of a light pair: illegal, unique state match, yellow.
module tl_pair_decode
    import tl_defs::*;
(
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    output logic       illegal,
    output logic       uniq_valid,
    output logic [2:0] uniq_state,
    output logic       yellow
);

    logic a_red_s;
    logic b_red_s;

    // Exactly one street must be red; only G/L pairs identify a single state.
    always_comb begin
        a_red_s    = (La == RED);
        b_red_s    = (Lb == RED);
        illegal    = (a_red_s == b_red_s);
        yellow     = !illegal && ((La == YELLOW) || (Lb == YELLOW));
        uniq_valid = 1'b0;
        uniq_state = S0;
        case ({La, Lb})
            {GREEN, RED}:  begin uniq_valid = 1'b1; uniq_state = S0; end
            {LEFT,  RED}:  begin uniq_valid = 1'b1; uniq_state = S2; end
            {RED,   GREEN}: begin uniq_valid = 1'b1; uniq_state = S4; end
            {RED,   LEFT}: begin uniq_valid = 1'b1; uniq_state = S6; end
            default:       begin uniq_valid = 1'b0; uniq_state = S0; end
        endcase
    end

endmodule

// File: rtl/tl_monitor.sv
// Traffic light bus monitor: reconstructs controller state and flags illegal/out-of-order/over-long-yellow.
// Optional cycle counter enabled by defining TL_MON_CNT_EN.
module tl_monitor
    import tl_defs::*;
#(
    parameter int YEL_MAX = 4,
    parameter int CW      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    output logic [2:0] q,
    output logic       locked,
    output logic       err_illegal,
    output logic       err_seq,
    output logic       err_dwell,
    output logic [7:0] cyc_cnt
);

    mon_mode_e     mode_r, mode_s;
    logic [2:0]    q_r, q_s, succ_s;
    logic [CW-1:0] dwell_r, dwell_s;
    logic          locked_r;
    logic          err_illegal_r, err_illegal_s;
    logic          err_seq_r, err_seq_s;
    logic          err_dwell_r, err_dwell_s;
    logic          adv_s;
    logic          illegal_s, uniq_valid_s, yellow_s;
    logic [2:0]    uniq_state_s;

    tl_pair_decode u_decode (
        .La         (La),
        .Lb         (Lb),
        .illegal    (illegal_s),
        .uniq_valid (uniq_valid_s),
        .uniq_state (uniq_state_s),
        .yellow     (yellow_s)
    );

    // Next mode, state, dwell count and error pulses.
    always_comb begin
        mode_s        = mode_r;
        q_s           = q_r;
        dwell_s       = dwell_r;
        err_illegal_s = 1'b0;
        err_seq_s     = 1'b0;
        err_dwell_s   = 1'b0;
        adv_s         = 1'b0;
        succ_s        = q_r + 3'd1;
        case (mode_r)
            MODE_UNLOCKED: begin
                if (illegal_s) begin
                    err_illegal_s = 1'b1;
                end else if (uniq_valid_s) begin
                    mode_s  = MODE_LOCKED;
                    q_s     = uniq_state_s;
                    dwell_s = {CW{1'b0}};
                end else begin
                    mode_s = MODE_UNLOCKED;
                end
            end
            MODE_LOCKED: begin
                if (illegal_s) begin
                    err_illegal_s = 1'b1;
                    mode_s        = MODE_UNLOCKED;
                end else if ({La, Lb} == exp_pair(q_r)) begin
                    // Saturating count; the yellow alarm fires only on the step onto YEL_MAX.
                    if (dwell_r != CW'(YEL_MAX)) begin
                        dwell_s     = dwell_r + CW'(1);
                        err_dwell_s = yellow_s && (dwell_r == CW'(YEL_MAX - 1));
                    end else begin
                        dwell_s = dwell_r;
                    end
                end else if ({La, Lb} == exp_pair(succ_s)) begin
                    q_s   = succ_s;
                    adv_s = 1'b1;
                end else begin
                    err_seq_s = 1'b1;
                    mode_s    = MODE_UNLOCKED;
                end
            end
            default: mode_s = MODE_UNLOCKED;
        endcase
        if (adv_s) begin
            dwell_s = {CW{1'b0}};
        end else begin
            dwell_s = dwell_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r        <= MODE_UNLOCKED;
            q_r           <= S0;
            dwell_r       <= {CW{1'b0}};
            locked_r      <= 1'b0;
            err_illegal_r <= 1'b0;
            err_seq_r     <= 1'b0;
            err_dwell_r   <= 1'b0;
        end else begin
            mode_r        <= mode_s;
            q_r           <= q_s;
            dwell_r       <= dwell_s;
            locked_r      <= (mode_s == MODE_LOCKED);
            err_illegal_r <= err_illegal_s;
            err_seq_r     <= err_seq_s;
            err_dwell_r   <= err_dwell_s;
        end
    end

`ifdef TL_MON_CNT_EN
    logic [7:0] cyc_r;
    logic       wrap_s;

    assign wrap_s = adv_s && (q_r == S7);

    // Full-cycle counter, wraps naturally at 255 and survives unlocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_r <= 8'd0;
        end else if (wrap_s) begin
            cyc_r <= cyc_r + 8'd1;
        end
    end

    assign cyc_cnt = cyc_r;
`else
    assign cyc_cnt = 8'd0;
`endif

    assign q           = q_r;
    assign locked      = locked_r;
    assign err_illegal = err_illegal_r;
    assign err_seq     = err_seq_r;
    assign err_dwell   = err_dwell_r;

endmodule

// File: tb/tb_tl_monitor.sv
// Directed self-checking bench for tl_monitor (YEL_MAX=4).
module tb_tl_monitor;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] L = 2'b10;
    localparam logic [1:0] R = 2'b11;
`ifdef TL_MON_CNT_EN
    localparam int CYC_ONE = 1;
`else
    localparam int CYC_ONE = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] La = 2'b11;
    logic [1:0] Lb = 2'b11;
    logic [2:0] q;
    logic       locked, err_illegal, err_seq, err_dwell;
    logic [7:0] cyc_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] walk_tbl [8];

    tl_monitor #(.YEL_MAX(4), .CW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .La          (La),
        .Lb          (Lb),
        .q           (q),
        .locked      (locked),
        .err_illegal (err_illegal),
        .err_seq     (err_seq),
        .err_dwell   (err_dwell),
        .cyc_cnt     (cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eq, input int el, input int ei,
                           input int es, input int ed, input int ec);
        chk({tag, ".q"},           int'(q),           eq);
        chk({tag, ".locked"},      int'(locked),      el);
        chk({tag, ".err_illegal"}, int'(err_illegal), ei);
        chk({tag, ".err_seq"},     int'(err_seq),     es);
        chk({tag, ".err_dwell"},   int'(err_dwell),   ed);
        chk({tag, ".cyc_cnt"},     int'(cyc_cnt),     ec);
    endtask

    task automatic step(input logic [1:0] a, input logic [1:0] b);
        La = a;
        Lb = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        walk_tbl[0] = {G, R}; walk_tbl[1] = {Y, R}; walk_tbl[2] = {L, R}; walk_tbl[3] = {Y, R};
        walk_tbl[4] = {R, G}; walk_tbl[5] = {R, Y}; walk_tbl[6] = {R, L}; walk_tbl[7] = {R, Y};

        // Reset state
        @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        #3;
        reset = 1'b0;

        // Ambiguous yellow start, then lock on G,R
        step(Y, R);
        chk_all("yel_start", 0, 0, 0, 0, 0, 0);
        step(G, R);
        chk_all("lock_s0", 0, 1, 0, 0, 0, 0);

        // Full walk S0..S7 -> S0, two edges per pair
        for (int s = 0; s <= 8; s++) begin
            for (int h = 0; h < 2; h++) begin
                step(walk_tbl[s % 8][3:2], walk_tbl[s % 8][1:0]);
                chk_all($sformatf("walk_s%0d_h%0d", s, h), s % 8, 1, 0, 0, 0,
                        (s == 8) ? CYC_ONE : 0);
            end
        end

        // Out-of-order: S2 then S4 pair
        step(Y, R);
        chk_all("to_s1", 1, 1, 0, 0, 0, CYC_ONE);
        step(L, R);
        chk_all("to_s2", 2, 1, 0, 0, 0, CYC_ONE);
        step(R, G);
        chk_all("seq_err", 2, 0, 0, 1, 0, CYC_ONE);
        step(R, G);
        chk_all("relock_s4", 4, 1, 0, 0, 0, CYC_ONE);

        // Illegal pairs, locked and unlocked
        step(G, G);
        chk_all("gg_locked", 4, 0, 1, 0, 0, CYC_ONE);
        step(G, G);
        chk_all("gg_unlocked", 4, 0, 1, 0, 0, CYC_ONE);
        step(R, R);
        chk_all("rr_unlocked", 4, 0, 1, 0, 0, CYC_ONE);
        step(G, R);
        chk_all("relock_s0", 0, 1, 0, 0, 0, CYC_ONE);
        step(R, R);
        chk_all("rr_locked", 0, 0, 1, 0, 0, CYC_ONE);
        step(G, R);
        chk_all("relock_s0b", 0, 1, 0, 0, 0, CYC_ONE);

        // Yellow dwell: seven edges of Y,R; entry edge then six holds, alarm on the fourth hold
        for (int k = 1; k <= 7; k++) begin
            step(Y, R);
            chk_all($sformatf("dwell_k%0d", k), 1, 1, 0, 0, (k == 5) ? 1 : 0, CYC_ONE);
        end
        step(L, R);
        chk_all("dwell_exit", 2, 1, 0, 0, 0, CYC_ONE);

        // Walk to S5, then asynchronous reset between edges
        step(Y, R);
        step(R, G);
        step(R, Y);
        chk_all("at_s5", 5, 1, 0, 0, 0, CYC_ONE);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        step(R, G);
        chk_all("post_rst_lock", 4, 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
